// File: rtl/idex_pipe_reg.sv
// ---------------------------------------------------------------------------
// idex_pipe_reg
// ID/EX pipeline register of the 5-stage core.
//
// Captures the decoded operands, register specifiers and control bits from ID
// and presents them to EX and to the forwarding unit. Edge priority is
// flush > stall > load.
//
// A writeback in the same cycle is folded into the captured or held operands.
// This keeps operands from going stale while EX is stalled.
//
// Optional feature (macro IDEX_PERF_EN): adds two 32-bit wrapping counters.
//   stall_cnt_o  : edges with stall_i=1 and flush_i=0
//   bubble_cnt_o : edges with flush_i=1
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   stall_i, flush_i        hold / bubble insert
//   pc_i, RS_data_i,
//   RT_data_i, imm_i        ID data fields
//   RegRs_i/Rt_i/Rd_i       register specifiers
//   ctrl_i[8:0]             {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc,
//                            ALUOp[1:0], RegDst, Branch}
//   WB_RegWr_i/RegRd_i/data_i  writeback port (write-through and refresh)
//   IDEX_*_o                registered copies, IDEX_valid_o=0 means bubble
// ---------------------------------------------------------------------------
module idex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] RS_data_i,
  input  logic [DATA_W-1:0] RT_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_W-1:0]  RegRs_i,
  input  logic [REG_W-1:0]  RegRt_i,
  input  logic [REG_W-1:0]  RegRd_i,
  input  logic [8:0]        ctrl_i,
  input  logic              WB_RegWr_i,
  input  logic [REG_W-1:0]  WB_RegRd_i,
  input  logic [DATA_W-1:0] WB_data_i,
  output logic [DATA_W-1:0] IDEX_pc_o,
  output logic [DATA_W-1:0] IDEX_RSdata_o,
  output logic [DATA_W-1:0] IDEX_RTdata_o,
  output logic [DATA_W-1:0] IDEX_imm_o,
  output logic [REG_W-1:0]  IDEX_RegRs_o,
  output logic [REG_W-1:0]  IDEX_RegRt_o,
  output logic [REG_W-1:0]  IDEX_RegRd_o,
  output logic [8:0]        IDEX_ctrl_o,
`ifdef IDEX_PERF_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o,
`endif
  output logic              IDEX_valid_o
);

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [8:0]        r_ctrl;
  logic              r_valid;

  // Writeback targets a real register ($0 is never written)
  logic w_wb_live;
  // Write-through on load: WB destination matches the incoming specifier
  logic w_wt_rs;
  logic w_wt_rt;
  // Refresh on stall: WB destination matches the held specifier of a real instruction
  logic w_rf_rs;
  logic w_rf_rt;

  assign w_wb_live = WB_RegWr_i && (WB_RegRd_i != '0);
  assign w_wt_rs   = w_wb_live && (WB_RegRd_i == RegRs_i);
  assign w_wt_rt   = w_wb_live && (WB_RegRd_i == RegRt_i);
  assign w_rf_rs   = r_valid && w_wb_live && (WB_RegRd_i == r_rs);
  assign w_rf_rt   = r_valid && w_wb_live && (WB_RegRd_i == r_rt);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
    end else if (flush_i) begin
      // Bubble: specifiers cleared too, so forwarding can never match it
      r_pc      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
    end else if (stall_i) begin
      if (w_rf_rs) r_rs_data <= WB_data_i;
      if (w_rf_rt) r_rt_data <= WB_data_i;
    end else begin
      r_pc      <= pc_i;
      r_rs_data <= w_wt_rs ? WB_data_i : RS_data_i;
      r_rt_data <= w_wt_rt ? WB_data_i : RT_data_i;
      r_imm     <= imm_i;
      r_rs      <= RegRs_i;
      r_rt      <= RegRt_i;
      r_rd      <= RegRd_i;
      r_ctrl    <= ctrl_i;
      r_valid   <= 1'b1;
    end
  end

  assign IDEX_pc_o     = r_pc;
  assign IDEX_RSdata_o = r_rs_data;
  assign IDEX_RTdata_o = r_rt_data;
  assign IDEX_imm_o    = r_imm;
  assign IDEX_RegRs_o  = r_rs;
  assign IDEX_RegRt_o  = r_rt;
  assign IDEX_RegRd_o  = r_rd;
  assign IDEX_ctrl_o   = r_ctrl;
  assign IDEX_valid_o  = r_valid;

`ifdef IDEX_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Both counters wrap naturally at 32 bits
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (flush_i)      r_bubble_cnt <= r_bubble_cnt + 32'd1;
      else if (stall_i) r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_idex_pipe_reg.sv
module tb_idex_pipe_reg;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i, flush_i;
  logic [31:0] pc_i, RS_data_i, RT_data_i, imm_i, WB_data_i;
  logic [4:0]  RegRs_i, RegRt_i, RegRd_i, WB_RegRd_i;
  logic [8:0]  ctrl_i;
  logic        WB_RegWr_i;
  logic [31:0] IDEX_pc_o, IDEX_RSdata_o, IDEX_RTdata_o, IDEX_imm_o;
  logic [4:0]  IDEX_RegRs_o, IDEX_RegRt_o, IDEX_RegRd_o;
  logic [8:0]  IDEX_ctrl_o;
  logic        IDEX_valid_o;
`ifdef IDEX_PERF_EN
  logic [31:0] stall_cnt_o, bubble_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  idex_pipe_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .RS_data_i(RS_data_i), .RT_data_i(RT_data_i), .imm_i(imm_i),
    .RegRs_i(RegRs_i), .RegRt_i(RegRt_i), .RegRd_i(RegRd_i), .ctrl_i(ctrl_i),
    .WB_RegWr_i(WB_RegWr_i), .WB_RegRd_i(WB_RegRd_i), .WB_data_i(WB_data_i),
    .IDEX_pc_o(IDEX_pc_o), .IDEX_RSdata_o(IDEX_RSdata_o), .IDEX_RTdata_o(IDEX_RTdata_o),
    .IDEX_imm_o(IDEX_imm_o), .IDEX_RegRs_o(IDEX_RegRs_o), .IDEX_RegRt_o(IDEX_RegRt_o),
    .IDEX_RegRd_o(IDEX_RegRd_o), .IDEX_ctrl_o(IDEX_ctrl_o),
`ifdef IDEX_PERF_EN
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o),
`endif
    .IDEX_valid_o(IDEX_valid_o)
  );

  typedef struct {
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [8:0]  ctrl;
    logic        valid;
    logic [31:0] scnt, bcnt;
  } exp_t;

  exp_t m;        // reference model state (what the stage should hold now)
  exp_t sb[$];    // scoreboard of expected post-edge contents
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t zero_state();
    exp_t z;
    z.pc = 0; z.rsd = 0; z.rtd = 0; z.imm = 0;
    z.rs = 0; z.rt = 0; z.rd = 0; z.ctrl = 0; z.valid = 0;
    z.scnt = 0; z.bcnt = 0;
    return z;
  endfunction

  // Value of architectural register `r` as seen this cycle: a live writeback to
  // a nonzero register supersedes the stale copy.
  function automatic logic [31:0] latest(input logic [4:0] r, input logic [31:0] stale);
    if (WB_RegWr_i && r != 0 && WB_RegRd_i == r) return WB_data_i;
    return stale;
  endfunction

  // Compute the next model state from current inputs, queue it, and advance one cycle.
  task automatic tick();
    exp_t n;
    n = m;
    if (flush_i) begin
      n = zero_state();
      n.scnt = m.scnt;
      n.bcnt = m.bcnt + 1;
    end else if (stall_i) begin
      n.scnt = m.scnt + 1;
      if (m.valid) begin
        n.rsd = latest(m.rs, m.rsd);
        n.rtd = latest(m.rt, m.rtd);
      end
    end else begin
      n.pc = pc_i; n.imm = imm_i; n.ctrl = ctrl_i; n.valid = 1;
      n.rs = RegRs_i; n.rt = RegRt_i; n.rd = RegRd_i;
      n.rsd = latest(RegRs_i, RS_data_i);
      n.rtd = latest(RegRt_i, RT_data_i);
    end
    m = n;
    sb.push_back(n);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_in(input logic st, input logic fl, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [8:0] ct,
                        input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd);
    stall_i = st; flush_i = fl; RS_data_i = rsd; RT_data_i = rtd;
    RegRs_i = rs; RegRt_i = rt; ctrl_i = ct;
    WB_RegWr_i = wbw; WB_RegRd_i = wbr; WB_data_i = wbd;
    pc_i = $urandom; imm_i = $urandom; RegRd_i = 5'($urandom_range(0, 31));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_pc"}, IDEX_pc_o, 0);
    chk({nm, "_rsd"}, IDEX_RSdata_o, 0);
    chk({nm, "_rtd"}, IDEX_RTdata_o, 0);
    chk({nm, "_imm"}, IDEX_imm_o, 0);
    chk({nm, "_rs"}, 32'(IDEX_RegRs_o), 0);
    chk({nm, "_rt"}, 32'(IDEX_RegRt_o), 0);
    chk({nm, "_rd"}, 32'(IDEX_RegRd_o), 0);
    chk({nm, "_ctrl"}, 32'(IDEX_ctrl_o), 0);
    chk({nm, "_valid"}, 32'(IDEX_valid_o), 0);
  endtask

  // Monitor: every edge the stage presents new contents; compare against the queue.
  always @(posedge clk_i) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("pc", IDEX_pc_o, mon_e.pc);
      chk("rs_data", IDEX_RSdata_o, mon_e.rsd);
      chk("rt_data", IDEX_RTdata_o, mon_e.rtd);
      chk("imm", IDEX_imm_o, mon_e.imm);
      chk("reg_rs", 32'(IDEX_RegRs_o), 32'(mon_e.rs));
      chk("reg_rt", 32'(IDEX_RegRt_o), 32'(mon_e.rt));
      chk("reg_rd", 32'(IDEX_RegRd_o), 32'(mon_e.rd));
      chk("ctrl", 32'(IDEX_ctrl_o), 32'(mon_e.ctrl));
      chk("valid", 32'(IDEX_valid_o), 32'(mon_e.valid));
`ifdef IDEX_PERF_EN
      chk("stall_cnt", stall_cnt_o, mon_e.scnt);
      chk("bubble_cnt", bubble_cnt_o, mon_e.bcnt);
`endif
    end
  end

  initial begin
    m = zero_state();
    rst_n_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst_n_i = 1'b1;

    // First load after reset
    set_in(0, 0, 32'h11, 32'h0, 5'd3, 5'd0, 9'h000, 0, 0, 0);
    tick();
    chk("first_rs", 32'(IDEX_RegRs_o), 3);
    chk("first_rsd", IDEX_RSdata_o, 32'h11);
    chk("first_valid", 32'(IDEX_valid_o), 1);

    // Stall hold for 3 edges with changing inputs
    set_in(0, 0, 32'h100, 32'h200, 5'd1, 5'd2, 9'h1A5, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, $urandom, $urandom, 5'($urandom), 5'($urandom), 9'($urandom), 0, 0, 0);
      tick();
    end
    chk("stall_ctrl_held", 32'(IDEX_ctrl_o), 32'h1A5);
    chk("stall_rsd_held", IDEX_RSdata_o, 32'h100);
    set_in(0, 0, 32'h300, 32'h400, 5'd4, 5'd6, 9'h0F0, 0, 0, 0);
    tick();
    chk("post_stall_ctrl", 32'(IDEX_ctrl_o), 32'h0F0);

    // Flush together with stall
    set_in(1, 1, $urandom, $urandom, 5'd9, 5'd10, 9'h1FF, 0, 0, 0);
    tick();
    chk("flush_ctrl", 32'(IDEX_ctrl_o), 0);
    chk("flush_valid", 32'(IDEX_valid_o), 0);
    chk("flush_rs", 32'(IDEX_RegRs_o), 0);

    // Write-through on load, Rs==Rt
    set_in(0, 0, 32'hAAAA, 32'hAAAA, 5'd5, 5'd5, 9'h080, 1, 5'd5, 32'h1234);
    tick();
    chk("wt_rsd", IDEX_RSdata_o, 32'h1234);
    chk("wt_rtd", IDEX_RTdata_o, 32'h1234);
    set_in(0, 0, 32'hAAAA, 32'hAAAA, 5'd0, 5'd5, 9'h080, 1, 5'd0, 32'h1234);
    tick();
    chk("wt_r0_rsd", IDEX_RSdata_o, 32'hAAAA);

    // Refresh during stall
    set_in(0, 0, 32'h20, 32'h10, 5'd2, 5'd7, 9'h100, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h99);
    tick();
    chk("refresh_rtd", IDEX_RTdata_o, 32'h99);
    chk("refresh_rsd", IDEX_RSdata_o, 32'h20);
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h99);
    tick();
    chk("bubble_no_refresh", IDEX_RTdata_o, 0);

    // Reset asserted mid-stall, between edges
    set_in(0, 0, 32'h55, 32'h66, 5'd8, 5'd9, 9'h1C3, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n_i = 1'b0;
    #1 chk_all_zero("async_reset");
    m = zero_state();
    @(negedge clk_i);
    rst_n_i = 1'b1;

`ifdef IDEX_PERF_EN
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("perf_stall4", stall_cnt_o, 4);
    chk("perf_bubble2", bubble_cnt_o, 2);
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_stall_cnt;
    m.scnt = 32'hFFFF_FFFF;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("perf_wrap", stall_cnt_o, 0);
`endif

    // Randomized traffic; small register range so matches are frequent
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
             $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             9'($urandom), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      tick();
    end

    #3;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/idex_pipe_reg.md
Name: idex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage core.
- Captures decoded operands, register specifiers and control bits from ID, then presents them to EX and to the forwarding unit (Rs/Rt specifiers, RegWrite).
- Supports stall (hold), flush (bubble insert) and a same-cycle writeback refresh, so held operands never go stale while EX waits.

Parameters:
DATA_W  32  operand / immediate / PC width
REG_W   5   register specifier width

Ports:
clk_i         in   1       clock, rising edge
rst_n_i       in   1       asynchronous, active-low reset
stall_i       in   1       hold current contents
flush_i       in   1       load a bubble (all control zero)
pc_i          in   DATA_W  ID-stage PC+4
RS_data_i     in   DATA_W  register file read port 1
RT_data_i     in   DATA_W  register file read port 2
imm_i         in   DATA_W  sign-extended immediate
RegRs_i       in   REG_W   Rs specifier
RegRt_i       in   REG_W   Rt specifier
RegRd_i       in   REG_W   Rd specifier
ctrl_i        in   9       {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst, Branch}
WB_RegWr_i    in   1       writeback enable
WB_RegRd_i    in   REG_W   writeback destination
WB_data_i     in   DATA_W  writeback data
IDEX_pc_o     out  DATA_W  registered PC+4
IDEX_RSdata_o out  DATA_W  registered Rs operand
IDEX_RTdata_o out  DATA_W  registered Rt operand
IDEX_imm_o    out  DATA_W  registered immediate
IDEX_RegRs_o  out  REG_W   registered Rs
IDEX_RegRt_o  out  REG_W   registered Rt
IDEX_RegRd_o  out  REG_W   registered Rd
IDEX_ctrl_o   out  9       registered control, same packing as ctrl_i
IDEX_valid_o  out  1       1 = real instruction, 0 = bubble

Behaviour:
- All outputs are registered; latency is 1 cycle from ID inputs to outputs.
- Reset: asynchronous on rst_n_i low. All outputs clear to 0, including IDEX_valid_o=0, so the register holds a bubble until the first load.
- Per rising edge, priority is flush > stall > load.
- Flush:
  - IDEX_ctrl_o=0 and IDEX_valid_o=0.
  - Specifiers Rs/Rt/Rd=0, so forwarding never matches on a bubble.
  - Data fields are don't-care; the implementation clears them to 0.
- Stall (flush=0): every field holds its value, except the operand refresh rule below.
- Load (flush=0, stall=0):
  - Capture all inputs; IDEX_valid_o=1.
  - Write-through: if WB_RegWr_i=1, WB_RegRd_i!=0 and WB_RegRd_i==RegRs_i, capture WB_data_i instead of RS_data_i. The same rule applies independently to Rt / RT_data_i.
- Operand refresh during stall: if WB_RegWr_i=1, WB_RegRd_i!=0 and WB_RegRd_i==IDEX_RegRs_o, replace IDEX_RSdata_o with WB_data_i. The same rule applies independently to Rt. The refresh is suppressed when IDEX_valid_o=0.
- Register 0: never write-through or refresh. Operands for $0 come straight from the register file value, which is 0.
- Rs==Rt with a matching WB write: both operands update.
- flush_i and stall_i together: flush wins and a bubble is loaded.
- Reset asserted mid-stall: the register clears immediately, with no dependence on the clock.

Optional Feature:
- Macro IDEX_PERF_EN.
- When defined, two extra outputs are present:
  - stall_cnt_o [31:0]: increments on each edge with stall_i=1 and flush_i=0.
  - bubble_cnt_o [31:0]: increments on each edge with flush_i=1.
- Both counters reset to 0 on rst_n_i low and wrap from 0xFFFFFFFF to 0.
- When undefined, the ports and logic are absent and the core behaviour is identical.

Test Plan:
- Reset: drive rst_n_i low asynchronously between edges -> all outputs 0 at once, IDEX_valid_o=0; after release with stall=flush=0, load RegRs=3, RS_data=0x11 -> next edge IDEX_RegRs_o=3, IDEX_RSdata_o=0x11, valid=1.
- Stall hold: load ctrl=0x1A5, then stall_i=1 for 3 cycles with the inputs changed -> outputs unchanged for all 3 edges; outputs update on the first edge after stall_i drops.
- Flush, including flush and stall together: valid instruction in the register, assert flush_i=1 with stall_i=1 -> IDEX_ctrl_o=0, IDEX_valid_o=0, IDEX_RegRs_o/Rt_o/Rd_o=0.
- Write-through on load: RegRs_i=5, RegRt_i=5, RS_data_i=RT_data_i=0xAAAA, WB_RegWr=1, WB_RegRd=5, WB_data=0x1234 -> both operands 0x1234; repeat with WB_RegRd=0 and RegRs=0 -> RS_data_i captured unchanged.
- Refresh during stall: held Rt=7, RTdata=0x10, stall_i=1, WB write reg 7 data 0x99 -> next edge IDEX_RTdata_o=0x99 and IDEX_RSdata_o unchanged; same stimulus with valid=0 -> no change.
- IDEX_PERF_EN: 4 stall cycles and 2 flush cycles, one of them with stall=1 -> stall_cnt_o=4, bubble_cnt_o=2; preload stall_cnt_o to 0xFFFFFFFF via a long run or force, then one stall -> 0.
